// File: rtl/sub_serial.sv
// Bit-serial subtractor: one full-subtractor cell computes diff = a - b - b_in
// LSB first over WIDTH cycles, with valid/ready handshakes on both sides.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic [WIDTH-1:0] diff_shift;
  logic             br_reg, br_next;
  logic             bout_reg, bout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             cell_d;
  logic             cell_br;

  // Full-subtractor cell on the current LSBs and the running borrow
  assign cell_d  = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign cell_br = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);

  // Result enters at the MSB so the first bit computed ends up at bit 0
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == WIDTH - 1) begin : g_msb
      assign diff_shift[gi] = cell_d;
    end else begin : g_low
      assign diff_shift[gi] = diff_reg[gi+1];
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    diff_next  = diff_reg;
    br_next    = br_reg;
    bout_next  = bout_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          br_next    = b_in;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        diff_next = diff_shift;
        a_next    = a_reg >> 1;
        b_next    = b_reg >> 1;
        br_next   = cell_br;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          bout_next  = cell_br;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_reg  <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      diff_reg  <= diff_next;
      br_reg    <= br_next;
      bout_reg  <= bout_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign diff  = diff_reg;
  assign b_out = bout_reg;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: directed vectors at WIDTH=1 and WIDTH=8,
// expected results queued at issue and checked by per-instance monitors.
module tb_sub_serial;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
  } exp8_t;

  typedef struct packed {
    logic d;
    logic bo;
  } exp1_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, b_in8, b_out8;
  logic [7:0] a8, b8, diff8;
  // WIDTH=1 instance
  logic       in_valid1, in_ready1, out_valid1, out_ready1, b_in1, b_out1;
  logic [0:0] a1, b1, diff1;

  sub_serial #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .b_in(b_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .b_out(b_out8)
  );

  sub_serial #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .b_in(b_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .b_out(b_out1)
  );

  exp8_t q8[$];
  exp1_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitors: one comparison pair per accepted result
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8: got diff=%0h b_out=%0b, expected no result", diff8, b_out8);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.d));
        chk("b_out8", 32'(b_out8), 32'(e.bo));
        $display("w8 result: diff=%0d b_out=%0b (expected %0d/%0b)", diff8, b_out8, e.d, e.bo);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected1: got diff=%0b b_out=%0b, expected no result", diff1, b_out1);
      end else begin
        exp1_t e;
        e = q1.pop_front();
        chk("diff1", 32'(diff1), 32'(e.d));
        chk("b_out1", 32'(b_out1), 32'(e.bo));
        $display("w1 result: diff=%0b b_out=%0b (expected %0b/%0b)", diff1, b_out1, e.d, e.bo);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input bit push,
                        input bit hold, output int tacc);
    bit ok;
    a8 = av; b8 = bv; b_in8 = bi; in_valid8 = 1'b1;
    ok = 1'b0;
    tacc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready8) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept8: got in_ready=0 for 100 cycles, expected 1");
    end else begin
      tacc = cyc;
      if (push) q8.push_back('{d: ed, bo: eb});
    end
    @(posedge clk); #1;
    if (!hold) in_valid8 = 1'b0;
  endtask

  task automatic issue1(input logic av, input logic bv, input logic bi,
                        input logic ed, input logic eb);
    bit ok;
    a1 = av; b1 = bv; b_in1 = bi; in_valid1 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept1: got in_ready=0 for 100 cycles, expected 1");
    end else begin
      q1.push_back('{d: ed, bo: eb});
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q8.size() == 0 && q1.size() == 0 && in_ready8 && in_ready1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain: got q8=%0d q1=%0d pending, expected 0", q8.size(), q1.size());
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] pat_bin, pat_a, pat_b, pat_d, pat_bo;
  int         t0, t1, n;
  bit         seen;
  int         acc[4];

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; b_in8 = 1'b0; out_ready8 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; b_in1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready8", 32'(in_ready8), 32'd1);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_b_out8", 32'(b_out8), 32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;

    // WIDTH=1 truth table
    pat_bin = 8'b0000_1111;
    pat_a   = 8'b0011_0011;
    pat_b   = 8'b0101_0101;
    pat_d   = 8'b0110_1001;
    pat_bo  = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      issue1(pat_a[i], pat_b[i], pat_bin[i], pat_d[i], pat_bo[i]);
    end
    wait_drain();

    // Basic op with latency measurement
    issue8(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b1, 1'b0, t0);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n++;
      if (out_valid8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("latency8", 32'(seen ? n : -1), 32'd9);
    wait_drain();

    // Borrow cases
    issue8(8'd5, 8'd10, 1'b0, 8'hFB, 1'b1, 1'b1, 1'b0, t0);
    issue8(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, t0);
    issue8(8'd255, 8'd255, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, t0);
    issue8(8'd128, 8'd127, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, t0);
    wait_drain();

    // Backpressure in DONE
    out_ready8 = 1'b0;
    issue8(8'd100, 8'd1, 1'b1, 8'd98, 1'b0, 1'b1, 1'b0, t0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_reach_done", 32'(seen), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd2; b_in8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
      chk("bp_diff", 32'(diff8), 32'd98);
      chk("bp_b_out", 32'(b_out8), 32'd0);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    chk("noreload_in_ready", 32'(in_ready8), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready8), 32'd1);
    chk("idle_out_valid", 32'(out_valid8), 32'd0);
    chk("idle_diff_kept", 32'(diff8), 32'd98);
    @(posedge clk); #1;
    wait_drain();

    // Reset while bit 3 is being computed
    issue8(8'd170, 8'd85, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, t0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready8), 32'd1);
    chk("abort_out_valid", 32'(out_valid8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_b_out", 32'(b_out8), 32'd0);
    @(posedge clk); #1;
    issue8(8'd37, 8'd80, 1'b0, 8'd213, 1'b1, 1'b1, 1'b0, t0);
    wait_drain();

    // Back-to-back with in_valid held high
    issue8(8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, acc[0]);
    issue8(8'd0, 8'd1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, acc[1]);
    issue8(8'd77, 8'd33, 1'b1, 8'd43, 1'b0, 1'b1, 1'b1, acc[2]);
    issue8(8'd255, 8'd0, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0, acc[3]);
    for (int i = 1; i < 4; i++) begin
      t1 = acc[i] - acc[i-1];
      chk("b2b_period", 32'(t1), 32'd10);
    end
    wait_drain();

    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier");
    $fatal(1, "watchdog");
  end

endmodule
